// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared types and constants for the LC-3 handshake controller
package lc3;

  typedef enum logic [1:0] {
    ALU_CONTROL_PASS = 2'd0,
    ALU_CONTROL_ADD  = 2'd1,
    ALU_CONTROL_AND  = 2'd2,
    ALU_CONTROL_NOT  = 2'd3
  } aluControl_t;

  typedef enum logic [5:0] {
    FETCH0, FETCH1, FETCH2, DECODE,
    ADD, AND, NOT, BR, JMP, JSR0, JSR1,
    LD0, LD1, LD2, LDR0, LDR1, LDR2,
    LDI0, LDI1, LDI2, LDI3, LDI4, LEA,
    ST0, STR0, STI0, STI1, STI2, ST_DATA, ST_WR,
    TRAP0, TRAP1, TRAP2, HALT, ERROR
  } state_t;

  localparam logic [3:0] OPCODE_BR   = 4'b0000;
  localparam logic [3:0] OPCODE_ADD  = 4'b0001;
  localparam logic [3:0] OPCODE_LD   = 4'b0010;
  localparam logic [3:0] OPCODE_ST   = 4'b0011;
  localparam logic [3:0] OPCODE_JSR  = 4'b0100;
  localparam logic [3:0] OPCODE_AND  = 4'b0101;
  localparam logic [3:0] OPCODE_LDR  = 4'b0110;
  localparam logic [3:0] OPCODE_STR  = 4'b0111;
  localparam logic [3:0] OPCODE_RTI  = 4'b1000;
  localparam logic [3:0] OPCODE_NOT  = 4'b1001;
  localparam logic [3:0] OPCODE_LDI  = 4'b1010;
  localparam logic [3:0] OPCODE_STI  = 4'b1011;
  localparam logic [3:0] OPCODE_JMP  = 4'b1100;
  localparam logic [3:0] OPCODE_RES  = 4'b1101;
  localparam logic [3:0] OPCODE_LEA  = 4'b1110;
  localparam logic [3:0] OPCODE_TRAP = 4'b1111;

  // PC mux: incrementer, address adder, bus
  localparam logic [1:0] SEL_PC_INC = 2'b00;
  localparam logic [1:0] SEL_PC_EAB = 2'b01;
  localparam logic [1:0] SEL_PC_BUS = 2'b10;

  localparam logic [1:0] SEL_EAB2_ZERO  = 2'b00;
  localparam logic [1:0] SEL_EAB2_OFF6  = 2'b01;
  localparam logic [1:0] SEL_EAB2_OFF9  = 2'b10;
  localparam logic [1:0] SEL_EAB2_OFF11 = 2'b11;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH1) || (s == LD1) || (s == LDR1) || (s == LDI1) ||
           (s == LDI3) || (s == STI1) || (s == TRAP1) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// rtl/lc3_mem_wait_timer.sv - counts unanswered memory request cycles and flags a timeout
module lc3_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = 8'd0;
    end else if (busy && !ready && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the limit cycle masks the timeout so the access completes.
  assign timeout = busy && !ready && (count_q == LIMIT);

endmodule

// File: rtl/lc3_hs_controller.sv
// rtl/lc3_hs_controller.sv - LC-3 control FSM with memReq/memReady handshake and bus timeout
module lc3_hs_controller
  import lc3::*;
#(
  parameter int   MEM_TIMEOUT     = 16,
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        flagN,
  input  logic        flagZ,
  input  logic        flagP,
  input  logic        memReady,
  output logic        memReq,
  output logic        memWE,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        enaMDR,
  output logic        enaPC,
  output logic        ldPC,
  output logic        enaMARM,
  output logic        selMAR,
  output logic        enaALU,
  output logic        regWE,
  output logic        flagWE,
  output logic        ldIR,
  output logic        selEAB1,
  output logic [1:0]  selPC,
  output logic [1:0]  selEAB2,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output aluControl_t aluControl,
  output logic        halted,
  output logic        busError
);

  state_t state_q;
  logic   halted_q;
  logic   bus_error_q;
  logic   in_wait;
  logic   timeout;
  logic   branch_taken;
  logic   unused_ir;

  assign in_wait      = is_wait_state(state_q);
  assign branch_taken = (flagN & ir[11]) | (flagZ & ir[10]) | (flagP & ir[9]);
  assign unused_ir    = ^ir[5:3];

  lc3_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (reset),
    .start  (!in_wait),
    .busy   (memReq),
    .ready  (memReady),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else if (timeout) begin
      state_q     <= ERROR;
      halted_q    <= 1'b1;
      bus_error_q <= 1'b1;
    end else begin
      case (state_q)
        FETCH0: state_q <= FETCH1;
        FETCH1: if (memReady) state_q <= FETCH2;
        FETCH2: state_q <= DECODE;
        DECODE: begin
          case (ir[15:12])
            OPCODE_ADD:  state_q <= ADD;
            OPCODE_AND:  state_q <= AND;
            OPCODE_NOT:  state_q <= NOT;
            OPCODE_BR:   state_q <= BR;
            OPCODE_JMP:  state_q <= JMP;
            OPCODE_JSR:  state_q <= JSR0;
            OPCODE_LD:   state_q <= LD0;
            OPCODE_LDR:  state_q <= LDR0;
            OPCODE_LDI:  state_q <= LDI0;
            OPCODE_LEA:  state_q <= LEA;
            OPCODE_ST:   state_q <= ST0;
            OPCODE_STR:  state_q <= STR0;
            OPCODE_STI:  state_q <= STI0;
            OPCODE_TRAP: state_q <= TRAP0;
            default: begin
              // RTI and the reserved opcode
              if (HALT_ON_ILLEGAL) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                state_q <= FETCH0;
              end
            end
          endcase
        end
        JSR0:    state_q <= JSR1;
        LD0:     state_q <= LD1;
        LD1:     if (memReady) state_q <= LD2;
        LDR0:    state_q <= LDR1;
        LDR1:    if (memReady) state_q <= LDR2;
        LDI0:    state_q <= LDI1;
        LDI1:    if (memReady) state_q <= LDI2;
        LDI2:    state_q <= LDI3;
        LDI3:    if (memReady) state_q <= LDI4;
        ST0:     state_q <= ST_DATA;
        STR0:    state_q <= ST_DATA;
        STI0:    state_q <= STI1;
        STI1:    if (memReady) state_q <= STI2;
        STI2:    state_q <= ST_DATA;
        ST_DATA: state_q <= ST_WR;
        ST_WR:   if (memReady) state_q <= FETCH0;
        TRAP0:   state_q <= TRAP1;
        TRAP1:   if (memReady) state_q <= TRAP2;
        HALT:    state_q <= HALT;
        ERROR:   state_q <= ERROR;
        default: state_q <= FETCH0;
      endcase
    end
  end

  always_comb begin
    memReq     = 1'b0;
    memWE      = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    selMDR     = 1'b0;
    enaMDR     = 1'b0;
    enaPC      = 1'b0;
    ldPC       = 1'b0;
    enaMARM    = 1'b0;
    selMAR     = 1'b0;
    enaALU     = 1'b0;
    regWE      = 1'b0;
    flagWE     = 1'b0;
    ldIR       = 1'b0;
    selEAB1    = 1'b0;
    selPC      = SEL_PC_INC;
    selEAB2    = SEL_EAB2_ZERO;
    aluControl = ALU_CONTROL_PASS;
    DR         = ir[11:9];
    SR1        = ir[8:6];
    SR2        = ir[2:0];
    case (state_q)
      FETCH0: begin
        enaPC = 1'b1;
        ldMAR = 1'b1;
      end
      FETCH1: begin
        // PC advances only on the completing cycle, however long the wait
        memReq = 1'b1;
        selMDR = 1'b1;
        ldMDR  = memReady;
        ldPC   = memReady;
      end
      FETCH2: begin
        enaMDR = 1'b1;
        ldIR   = 1'b1;
      end
      ADD, AND, NOT: begin
        enaALU = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
        aluControl = (state_q == ADD) ? ALU_CONTROL_ADD :
                     (state_q == AND) ? ALU_CONTROL_AND : ALU_CONTROL_NOT;
      end
      BR: begin
        if (branch_taken) begin
          ldPC    = 1'b1;
          selPC   = SEL_PC_EAB;
          selEAB2 = SEL_EAB2_OFF9;
        end
      end
      JMP: begin
        ldPC    = 1'b1;
        selPC   = SEL_PC_EAB;
        selEAB1 = 1'b1;
      end
      JSR0, TRAP0: begin
        enaPC = 1'b1;
        regWE = 1'b1;
        DR    = 3'd7;
      end
      JSR1: begin
        ldPC  = 1'b1;
        selPC = SEL_PC_EAB;
        if (ir[11]) begin
          selEAB2 = SEL_EAB2_OFF11;
        end else begin
          selEAB1 = 1'b1;
        end
      end
      LD0, LDI0, ST0, STI0: begin
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        selEAB2 = SEL_EAB2_OFF9;
      end
      LDR0, STR0: begin
        enaMARM = 1'b1;
        ldMAR   = 1'b1;
        selEAB1 = 1'b1;
        selEAB2 = SEL_EAB2_OFF6;
      end
      LD1, LDR1, LDI1, LDI3, STI1: begin
        memReq = 1'b1;
        selMDR = 1'b1;
        ldMDR  = memReady;
      end
      LDI2, STI2: begin
        enaMDR = 1'b1;
        ldMAR  = 1'b1;
      end
      LD2, LDR2, LDI4: begin
        enaMDR = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
      end
      LEA: begin
        enaMARM = 1'b1;
        selEAB2 = SEL_EAB2_OFF9;
        regWE   = 1'b1;
      end
      ST_DATA: begin
        SR1    = ir[11:9];
        enaALU = 1'b1;
        ldMDR  = 1'b1;
      end
      ST_WR: begin
        memReq = 1'b1;
        memWE  = memReady;
      end
      TRAP1: begin
        enaMARM = 1'b1;
        selMAR  = 1'b1;
        ldMAR   = 1'b1;
        memReq  = 1'b1;
        selMDR  = 1'b1;
        ldMDR   = memReady;
      end
      TRAP2: begin
        enaMDR = 1'b1;
        ldPC   = 1'b1;
        selPC  = SEL_PC_BUS;
      end
      default: ;
    endcase
  end

  assign halted   = halted_q;
  assign busError = bus_error_q;

endmodule

// File: tb/tb_lc3_hs_controller.sv
// tb/tb_lc3_hs_controller.sv - scoreboard bench for lc3_hs_controller
module tb_lc3_hs_controller;
  import lc3::*;

  typedef struct packed {
    logic memReq, memWE, ldMAR, ldMDR, selMDR, enaMDR, enaPC, ldPC, enaMARM;
    logic selMAR, enaALU, regWE, flagWE, ldIR, selEAB1, halted, busError;
    logic [1:0] selPC, selEAB2, alu;
    logic [2:0] DR, SR1, SR2;
  } ov_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        flagN = 1'b0, flagZ = 1'b0, flagP = 1'b0;
  logic        memReady = 1'b0;

  logic a_memReq, a_memWE, a_ldMAR, a_ldMDR, a_selMDR, a_enaMDR, a_enaPC, a_ldPC, a_enaMARM;
  logic a_selMAR, a_enaALU, a_regWE, a_flagWE, a_ldIR, a_selEAB1, a_halted, a_busError;
  logic [1:0] a_selPC, a_selEAB2;
  logic [2:0] a_DR, a_SR1, a_SR2;
  aluControl_t a_alu;

  logic b_memReq, b_memWE, b_ldMAR, b_ldMDR, b_selMDR, b_enaMDR, b_enaPC, b_ldPC, b_enaMARM;
  logic b_selMAR, b_enaALU, b_regWE, b_flagWE, b_ldIR, b_selEAB1, b_halted, b_busError;
  logic [1:0] b_selPC, b_selEAB2;
  logic [2:0] b_DR, b_SR1, b_SR2;
  aluControl_t b_alu;

  int checks = 0;
  int errors = 0;

  ov_t   exp_q[$];
  string tag_q[$];
  ov_t   exp_b_q[$];

  always #5 clk = ~clk;

  lc3_hs_controller #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
    .memReady(memReady), .memReq(a_memReq), .memWE(a_memWE), .ldMAR(a_ldMAR),
    .ldMDR(a_ldMDR), .selMDR(a_selMDR), .enaMDR(a_enaMDR), .enaPC(a_enaPC), .ldPC(a_ldPC),
    .enaMARM(a_enaMARM), .selMAR(a_selMAR), .enaALU(a_enaALU), .regWE(a_regWE),
    .flagWE(a_flagWE), .ldIR(a_ldIR), .selEAB1(a_selEAB1), .selPC(a_selPC),
    .selEAB2(a_selEAB2), .DR(a_DR), .SR1(a_SR1), .SR2(a_SR2), .aluControl(a_alu),
    .halted(a_halted), .busError(a_busError)
  );

  lc3_hs_controller #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
    .memReady(memReady), .memReq(b_memReq), .memWE(b_memWE), .ldMAR(b_ldMAR),
    .ldMDR(b_ldMDR), .selMDR(b_selMDR), .enaMDR(b_enaMDR), .enaPC(b_enaPC), .ldPC(b_ldPC),
    .enaMARM(b_enaMARM), .selMAR(b_selMAR), .enaALU(b_enaALU), .regWE(b_regWE),
    .flagWE(b_flagWE), .ldIR(b_ldIR), .selEAB1(b_selEAB1), .selPC(b_selPC),
    .selEAB2(b_selEAB2), .DR(b_DR), .SR1(b_SR1), .SR2(b_SR2), .aluControl(b_alu),
    .halted(b_halted), .busError(b_busError)
  );

  ov_t obs_a, obs_b;
  assign obs_a = {a_memReq, a_memWE, a_ldMAR, a_ldMDR, a_selMDR, a_enaMDR, a_enaPC, a_ldPC,
                  a_enaMARM, a_selMAR, a_enaALU, a_regWE, a_flagWE, a_ldIR, a_selEAB1,
                  a_halted, a_busError, a_selPC, a_selEAB2, a_alu, a_DR, a_SR1, a_SR2};
  assign obs_b = {b_memReq, b_memWE, b_ldMAR, b_ldMDR, b_selMDR, b_enaMDR, b_enaPC, b_ldPC,
                  b_enaMARM, b_selMAR, b_enaALU, b_regWE, b_flagWE, b_ldIR, b_selEAB1,
                  b_halted, b_busError, b_selPC, b_selEAB2, b_alu, b_DR, b_SR1, b_SR2};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h want %08h", tag, $time, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    ov_t   e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs_a, e);
      if (exp_b_q.size() > 0) begin
        e = exp_b_q.pop_front();
        check_eq({"nop_", t}, obs_b, e);
      end
    end
  end

  function automatic ov_t base(input logic [15:0] i);
    ov_t v;
    v     = '0;
    v.DR  = i[11:9];
    v.SR1 = i[8:6];
    v.SR2 = i[2:0];
    v.alu = ALU_CONTROL_PASS;
    return v;
  endfunction

  function automatic ov_t fetch0_vec(input logic [15:0] i);
    ov_t v;
    v = base(i);
    v.enaPC = 1'b1;
    v.ldMAR = 1'b1;
    return v;
  endfunction

  task automatic cyc(input string t, input ov_t e, input logic rdy);
    memReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] i, input int d, input logic idle);
    ov_t v;
    ir = i;
    cyc("FETCH0", fetch0_vec(i), idle);
    for (int k = 0; k < d; k++) begin
      v = base(i); v.memReq = 1; v.selMDR = 1;
      cyc("FETCH1_wait", v, 1'b0);
    end
    v = base(i); v.memReq = 1; v.selMDR = 1; v.ldMDR = 1; v.ldPC = 1;
    cyc("FETCH1_done", v, 1'b1);
    v = base(i); v.enaMDR = 1; v.ldIR = 1;
    cyc("FETCH2", v, idle);
    cyc("DECODE", base(i), idle);
  endtask

  task automatic read_now(input string t, input logic [15:0] i);
    ov_t v;
    v = base(i); v.memReq = 1; v.selMDR = 1; v.ldMDR = 1;
    cyc(t, v, 1'b1);
  endtask

  task automatic mar_off9(input string t, input logic [15:0] i);
    ov_t v;
    v = base(i); v.enaMARM = 1; v.ldMAR = 1; v.selEAB2 = 2'b10;
    cyc(t, v, 1'b0);
  endtask

  task automatic store_tail(input logic [15:0] i, input int d);
    ov_t v;
    v = base(i); v.SR1 = i[11:9]; v.enaALU = 1; v.ldMDR = 1;
    cyc("ST_DATA", v, 1'b0);
    for (int k = 0; k < d; k++) begin
      v = base(i); v.memReq = 1;
      cyc("ST_WR_wait", v, 1'b0);
    end
    v = base(i); v.memReq = 1; v.memWE = 1;
    cyc("ST_WR_done", v, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("RESET", fetch0_vec(ir), 1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] i;
    logic [2:0]  nzp;
    logic        taken;
  } br_t;

  br_t br_tab[6] = '{
    '{16'h0E05, 3'b001, 1'b1},
    '{16'h0005, 3'b111, 1'b0},
    '{16'h0805, 3'b010, 1'b0},
    '{16'h0805, 3'b100, 1'b1},
    '{16'h0405, 3'b010, 1'b1},
    '{16'h0205, 3'b100, 1'b0}
  };

  initial begin
    ov_t v;
    @(posedge clk);
    #1;
    cyc("RESET", fetch0_vec(16'h0000), 1'b0);
    reset = 1'b0;

    // ADD with three stalled cycles: ready lands on the timeout cycle and must win
    fetch(16'h12A3, 3, 1'b0);
    v = base(16'h12A3); v.enaALU = 1; v.regWE = 1; v.flagWE = 1; v.alu = ALU_CONTROL_ADD;
    cyc("ADD", v, 1'b0);

    // memReady high outside wait states is ignored
    fetch(16'h5283, 0, 1'b1);
    v = base(16'h5283); v.enaALU = 1; v.regWE = 1; v.flagWE = 1; v.alu = ALU_CONTROL_AND;
    cyc("AND", v, 1'b1);

    fetch(16'h927F, 1, 1'b0);
    v = base(16'h927F); v.enaALU = 1; v.regWE = 1; v.flagWE = 1; v.alu = ALU_CONTROL_NOT;
    cyc("NOT", v, 1'b0);

    fetch(16'h2205, 0, 1'b0);
    mar_off9("LD0", 16'h2205);
    v = base(16'h2205); v.memReq = 1; v.selMDR = 1;
    cyc("LD1_wait", v, 1'b0);
    read_now("LD1_done", 16'h2205);
    v = base(16'h2205); v.enaMDR = 1; v.regWE = 1; v.flagWE = 1;
    cyc("LD2", v, 1'b0);

    fetch(16'h6285, 0, 1'b0);
    v = base(16'h6285); v.enaMARM = 1; v.ldMAR = 1; v.selEAB1 = 1; v.selEAB2 = 2'b01;
    cyc("LDR0", v, 1'b0);
    read_now("LDR1", 16'h6285);
    v = base(16'h6285); v.enaMDR = 1; v.regWE = 1; v.flagWE = 1;
    cyc("LDR2", v, 1'b0);

    fetch(16'hA205, 0, 1'b0);
    mar_off9("LDI0", 16'hA205);
    read_now("LDI1", 16'hA205);
    v = base(16'hA205); v.enaMDR = 1; v.ldMAR = 1;
    cyc("LDI2", v, 1'b0);
    read_now("LDI3", 16'hA205);
    v = base(16'hA205); v.enaMDR = 1; v.regWE = 1; v.flagWE = 1;
    cyc("LDI4", v, 1'b0);

    fetch(16'hE205, 0, 1'b0);
    v = base(16'hE205); v.enaMARM = 1; v.selEAB2 = 2'b10; v.regWE = 1;
    cyc("LEA", v, 1'b0);

    foreach (br_tab[n]) begin
      {flagN, flagZ, flagP} = br_tab[n].nzp;
      fetch(br_tab[n].i, 0, 1'b0);
      v = base(br_tab[n].i);
      if (br_tab[n].taken) begin
        v.ldPC = 1; v.selPC = 2'b01; v.selEAB2 = 2'b10;
      end
      cyc("BR", v, 1'b0);
    end

    fetch(16'hC1C0, 0, 1'b0);
    v = base(16'hC1C0); v.ldPC = 1; v.selPC = 2'b01; v.selEAB1 = 1;
    cyc("JMP", v, 1'b0);

    fetch(16'h4805, 0, 1'b0);
    v = base(16'h4805); v.enaPC = 1; v.regWE = 1; v.DR = 3'd7;
    cyc("JSR0", v, 1'b0);
    v = base(16'h4805); v.ldPC = 1; v.selPC = 2'b01; v.selEAB2 = 2'b11;
    cyc("JSR1", v, 1'b0);

    fetch(16'h4080, 0, 1'b0);
    v = base(16'h4080); v.enaPC = 1; v.regWE = 1; v.DR = 3'd7;
    cyc("JSRR0", v, 1'b0);
    v = base(16'h4080); v.ldPC = 1; v.selPC = 2'b01; v.selEAB1 = 1;
    cyc("JSRR1", v, 1'b0);

    fetch(16'h3205, 0, 1'b0);
    mar_off9("ST0", 16'h3205);
    store_tail(16'h3205, 1);

    fetch(16'h7285, 0, 1'b0);
    v = base(16'h7285); v.enaMARM = 1; v.ldMAR = 1; v.selEAB1 = 1; v.selEAB2 = 2'b01;
    cyc("STR0", v, 1'b0);
    store_tail(16'h7285, 0);

    fetch(16'hB205, 0, 1'b0);
    mar_off9("STI0", 16'hB205);
    read_now("STI1", 16'hB205);
    v = base(16'hB205); v.enaMDR = 1; v.ldMAR = 1;
    cyc("STI2", v, 1'b0);
    store_tail(16'hB205, 0);

    fetch(16'hF025, 0, 1'b0);
    v = base(16'hF025); v.enaPC = 1; v.regWE = 1; v.DR = 3'd7;
    cyc("TRAP0", v, 1'b0);
    v = base(16'hF025); v.enaMARM = 1; v.selMAR = 1; v.ldMAR = 1;
    v.memReq = 1; v.selMDR = 1; v.ldMDR = 1;
    cyc("TRAP1", v, 1'b1);
    v = base(16'hF025); v.enaMDR = 1; v.ldPC = 1; v.selPC = 2'b10;
    cyc("TRAP2", v, 1'b0);

    // Fetch never answered: four wait cycles, then sticky ERROR
    ir = 16'h12A3;
    cyc("TO_FETCH0", fetch0_vec(ir), 1'b0);
    for (int k = 0; k < 4; k++) begin
      v = base(ir); v.memReq = 1; v.selMDR = 1;
      cyc("TO_FETCH1", v, 1'b0);
    end
    v = base(ir); v.halted = 1; v.busError = 1;
    cyc("ERROR", v, 1'b0);
    cyc("ERROR_rdy", v, 1'b1);
    cyc("ERROR_hold", v, 1'b0);
    do_reset();

    // Reserved opcode: halt on one instance, treated as NOP on the other
    fetch(16'hD000, 0, 1'b0);
    v = base(16'hD000); v.halted = 1;
    exp_b_q.push_back(fetch0_vec(16'hD000));
    cyc("ILLEGAL", v, 1'b0);
    cyc("HALT_rdy", v, 1'b1);
    cyc("HALT_hold", v, 1'b0);
    do_reset();

    // Reset in the middle of a load wait
    fetch(16'h2205, 0, 1'b0);
    mar_off9("LD0", 16'h2205);
    v = base(16'h2205); v.memReq = 1; v.selMDR = 1;
    cyc("LD1_wait", v, 1'b0);
    reset = 1'b1;
    cyc("RST_MID_LD1", fetch0_vec(16'h2205), 1'b0);
    cyc("RST_HOLD", fetch0_vec(16'h2205), 1'b1);
    reset = 1'b0;
    fetch(16'h12A3, 0, 1'b0);
    v = base(16'h12A3); v.enaALU = 1; v.regWE = 1; v.flagWE = 1; v.alu = ALU_CONTROL_ADD;
    cyc("ADD_after_reset", v, 1'b0);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", 32'(exp_q.size() + exp_b_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
